// File: rtl/mem_writeback_pkg.sv
// Shared RISC-V constants for the writeback stage: opcodes, load funct3 codes
// and the writeback FSM state encoding.
package mem_writeback_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      S_IDLE      = 1'b0,
      S_WAIT_LOAD = 1'b1
   } wb_state_e;

endpackage

// File: rtl/mem_writeback_if.sv
// Execute-to-writeback bundle: instruction, load data return, regfile write
// and decode bypass. master = pipeline/memory side, slave = writeback stage.
interface mem_writeback_if;

   logic        exec;
   logic        reg_we;
   logic        mem_rr;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [31:0] result;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        stall;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;

   modport master (
      output exec, reg_we, mem_rr, funct3, rd, result, dmem_rvalid, dmem_rdata,
      input  stall, we, wa, wd, fwd_valid, fwd_rd, fwd_data
   );

   modport slave (
      input  exec, reg_we, mem_rr, funct3, rd, result, dmem_rvalid, dmem_rdata,
      output stall, we, wa, wd, fwd_valid, fwd_rd, fwd_data
   );

endinterface

// File: rtl/mem_writeback_load_extend.sv
// Picks the addressed byte/half/word out of an aligned load word and
// sign- or zero-extends it to 32 bits.
module load_extend
   import mem_writeback_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_d;
   logic [15:0] half_d;

   always_comb begin
      byte_d = word_i[8*offset_i +: 8];
      // Halfword select uses only offset[1]; a misaligned offset[0] is dropped.
      half_d = word_i[16*offset_i[1] +: 16];
      case (funct3_i)
         F3_LB:   data_o = {{24{byte_d[7]}}, byte_d};
         F3_LH:   data_o = {{16{half_d[15]}}, half_d};
         F3_LBU:  data_o = {24'd0, byte_d};
         F3_LHU:  data_o = {16'd0, half_d};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_writeback.sv
// Writeback stage: registers ALU results directly and holds loads in a
// one-deep wait state until data returns. Define WB_BYPASS_EN to drive fwd_*.
//
// state       | meaning
// S_IDLE      | accepting instructions from execute
// S_WAIT_LOAD | load accepted, stalling upstream until dmem_rvalid
module mem_writeback
   import mem_writeback_pkg::*;
(
   input logic            clk,
   input logic            rst_n,
   mem_writeback_if.slave wb
);

   wb_state_e   state_q;
   logic        we_q;
   logic [4:0]  wa_q;
   logic [31:0] wd_q;
   logic [4:0]  ld_rd_q;
   logic [2:0]  ld_f3_q;
   logic        ld_we_q;
   logic [1:0]  ld_off_q;
   logic [31:0] ld_data_d;

   load_extend u_load_extend (
      .funct3_i (ld_f3_q),
      .offset_i (ld_off_q),
      .word_i   (wb.dmem_rdata),
      .data_o   (ld_data_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         wa_q     <= '0;
         wd_q     <= '0;
         ld_rd_q  <= '0;
         ld_f3_q  <= '0;
         ld_we_q  <= 1'b0;
         ld_off_q <= '0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (wb.exec) begin
                  if (wb.mem_rr) begin
                     ld_rd_q  <= wb.rd;
                     ld_f3_q  <= wb.funct3;
                     ld_we_q  <= wb.reg_we;
                     ld_off_q <= wb.result[1:0];
                     state_q  <= S_WAIT_LOAD;
                  end else begin
                     we_q <= wb.reg_we & (wb.rd != 5'd0);
                     wa_q <= wb.rd;
                     wd_q <= wb.result;
                  end
               end
            end
            S_WAIT_LOAD: begin
               // exec is ignored here; upstream re-presents it once stall drops.
               if (wb.dmem_rvalid) begin
                  we_q    <= ld_we_q & (ld_rd_q != 5'd0);
                  wa_q    <= ld_rd_q;
                  wd_q    <= ld_data_d;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wb.stall = (state_q == S_WAIT_LOAD);
   assign wb.we    = we_q;
   assign wb.wa    = wa_q;
   assign wb.wd    = wd_q;

`ifdef WB_BYPASS_EN
   assign wb.fwd_valid = we_q;
   assign wb.fwd_rd    = wa_q;
   assign wb.fwd_data  = wd_q;
`else
   assign wb.fwd_valid = 1'b0;
   assign wb.fwd_rd    = '0;
   assign wb.fwd_data  = '0;
`endif

endmodule
